seg_display_sched: RTL and testbench
====================================

Name: seg_display_sched

Overview:
Time-shares the 4-digit seven-segment display between up to NUM_REQ independent BCD sources (e.g. counter, timer, status code).
- Grants one requester at a time for a programmable dwell window, round-robin.
- Urgent requests preempt the current owner.
- bcd_data_op feeds the 16-bit BCD input of the display driver. Nibble values above 9 display blank.
- Runs in the clk_100mhz domain with an internal 1 ms tick prescaler.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CLK_DIV, 100000, clk_100mhz cycles per 1 ms tick
DWELL_MS, 2000, ms each owner holds the display before rearbitration
IDLE_BCD, 16'hFFFF, value driven when no owner (all digits blank)
BLINK_MS, 250, blink half-period in ms (used only with SEG_SCHED_BLINK_EN)

Ports:
clk_100mhz  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  level request per requester
urgent  in  NUM_REQ  urgent qualifier; ignored unless matching req bit is high
bcd_in  in  16*NUM_REQ  packed BCD; requester i at [16i+15:16i]
grant  out  NUM_REQ  one-hot owner indication, registered
active_id  out  $clog2(NUM_REQ)  index of current or last owner
bcd_data_op  out  16  BCD to display driver, registered
switch_pulse  out  1  one-cycle pulse when ownership moves to a different requester or out of IDLE

Behaviour:
- Clock and reset: single clock. Reset is synchronous and active-high, sampled on the clk_100mhz edge. Reset has priority over all other events; asserting it mid-operation returns every register to its reset value on the next edge.
- Reset values:
  - state = IDLE, grant = 0, active_id = 0, switch_pulse = 0, bcd_data_op = IDLE_BCD
  - prescaler = 0, dwell counter = 0
  - last_owner = NUM_REQ-1, so the first round-robin search starts at 0
- Tick prescaler: free-running 0..CLK_DIV-1. tick is high for one cycle when the count equals CLK_DIV-1, then wraps to 0.
- IDLE:
  - grant = 0, bcd_data_op = IDLE_BCD.
  - Any req bit high moves to ARB on the next edge.
- ARB (exactly one cycle):
  - grant = 0 and bcd_data_op holds its previous value.
  - Selection: if any (req & urgent), pick the lowest such index. Otherwise search (last_owner+1) mod NUM_REQ upward with wrap and pick the first req bit set.
  - If no req is high, go to IDLE and load bcd_data_op = IDLE_BCD.
  - Otherwise, on exit: set grant one-hot, active_id = winner, last_owner = winner, dwell = DWELL_MS; go to HOLD.
  - switch_pulse fires on the exit edge if the winner differs from the previous active_id, or if ARB was entered from IDLE.
- HOLD:
  - bcd_data_op <= bcd_in[owner] every cycle (1-cycle latency from a bcd_in change).
  - dwell decrements by 1 on each tick and saturates at 0.
  - Exits to ARB, checked in priority order:
    1. owner req low
    2. owner not urgent and another requester has req & urgent (preemption)
    3. dwell == 0
  - An urgent owner is not preempted by another urgent requester; it releases only on dwell expiry or req drop.
  - On dwell expiry with only the owner requesting, ARB re-grants the same owner. The one-cycle grant gap occurs and switch_pulse does not fire.
- Simultaneous events: an owner req drop in the same cycle as dwell expiry is handled as a req drop. The result is identical: one ARB cycle.
- Width rule: dwell counter is $clog2(DWELL_MS+1) bits. prescaler is $clog2(CLK_DIV) bits.

Optional Feature:
- Macro: SEG_SCHED_BLINK_EN.
- Defined: while the current owner was granted via the urgent path, bcd_data_op alternates between bcd_in[owner] and IDLE_BCD every BLINK_MS ticks.
  - The blink phase restarts at "shown" on each grant.
  - Non-urgent owners display steadily.
- Undefined: no blink logic or blink counter is instantiated; all owners display steadily.

Test Plan:
Sim parameters: CLK_DIV=10, DWELL_MS=4, NUM_REQ=4.
1. Reset, then req=4'b0001 with bcd_in[0]=16'h1234 -> one ARB cycle, grant=0001, switch_pulse=1 for one cycle, bcd_data_op=16'h1234 one cycle later.
2. req=4'b0101 held steady -> grant alternates 0001/0100 every 40 cycles (4 ticks) plus the 1-cycle ARB gap; switch_pulse at each change.
3. Owner 0 holding; at cycle 15 assert req[3] & urgent[3] -> next cycle ARB, then grant=1000. Assert urgent[1]&req[1] while 3 is owner -> no preemption until dwell expiry.
4. Only req[2] high for 100 cycles -> grant=0100 with a one-cycle 0 gap every 4 ticks, switch_pulse never re-fires, bcd_data_op stable.
5. Owner drops req with no other requests -> ARB then IDLE, bcd_data_op=16'hFFFF, grant=0. Assert reset mid-HOLD -> all outputs at reset values on the next edge.
6. With SEG_SCHED_BLINK_EN, BLINK_MS=1, urgent owner data 16'h0999 -> bcd_data_op toggles 16'h0999/16'hFFFF every 10 cycles. Without the macro it stays 16'h0999.

Source files
------------

// File: rtl/seg_display_sched.sv
// seg_display_sched: time-shares one 4-digit BCD display between NUM_REQ sources.
// Round-robin ownership with a dwell window measured in 1 ms ticks. Urgent
// requesters preempt a non-urgent owner.
// Optional build macro SEG_SCHED_BLINK_EN: an owner granted through the urgent
// path blinks between its data and IDLE_BCD every BLINK_MS ticks.
module seg_display_sched #(
    parameter int          NUM_REQ  = 4,
    parameter int          CLK_DIV  = 100000,
    parameter int          DWELL_MS = 2000,
    parameter logic [15:0] IDLE_BCD = 16'hFFFF,
    parameter int          BLINK_MS = 250
) (
    input  logic                       clk_100mhz,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         urgent,
    input  logic [16*NUM_REQ-1:0]      bcd_in,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic [15:0]                bcd_data_op,
    output logic                       switch_pulse
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(DWELL_MS + 1);

    // Elaboration-time sanity check on the configuration.
    if (NUM_REQ < 2 || NUM_REQ > 8 || CLK_DIV < 1 || DWELL_MS < 1 || BLINK_MS < 1) begin : g_bad_param
        $error("seg_display_sched: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARB  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  state;
    logic [PW-1:0]           presc;
    logic                    tick;
    logic [DW-1:0]           dwell;
    logic [IW-1:0]           last_owner;
    logic                    from_idle;

    // Per-requester view of the packed BCD bus.
    logic [NUM_REQ-1:0][15:0] bcd_arr;
    logic [15:0]              owner_bcd;
    logic [15:0]              hold_data;

    // Arbitration results.
    logic                    any_req;
    logic                    urg_hit;
    logic [IW-1:0]           urg_idx;
    logic                    hi_hit;
    logic [IW-1:0]           hi_idx;
    logic [IW-1:0]           lo_idx;
    logic [IW-1:0]           win_idx;

    // Owner status used by the HOLD exit conditions.
    logic                    owner_req;
    logic                    owner_urg;
    logic                    other_urg;
    logic                    hold_exit;

    assign bcd_arr   = bcd_in;
    assign owner_bcd = bcd_arr[active_id];
    assign owner_req = req[active_id];
    assign owner_urg = urgent[active_id];
    // grant is the owner's one-hot while in HOLD, so it masks the owner out.
    assign other_urg = |(req & urgent & ~grant);
    assign any_req   = |req;
    assign tick      = (presc == PW'(CLK_DIV - 1));

    // Priority order: owner drop, urgent preemption of a non-urgent owner, dwell expiry.
    assign hold_exit = !owner_req || (!owner_urg && other_urg) || (dwell == '0);

    // Free-running 1 ms prescaler; tick marks the last count before wrap.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Winner selection: lowest urgent index first, else round-robin after last_owner.
    always_comb begin
        urg_hit = 1'b0;
        urg_idx = '0;
        hi_hit  = 1'b0;
        hi_idx  = '0;
        lo_idx  = '0;
        // Descending scan so the lowest qualifying index is the one left standing.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && urgent[i]) begin
                urg_hit = 1'b1;
                urg_idx = IW'(i);
            end
            if (req[i]) begin
                if (i > int'(last_owner)) begin
                    hi_hit = 1'b1;
                    hi_idx = IW'(i);
                end else begin
                    lo_idx = IW'(i);
                end
            end
        end
        // Indices above last_owner come before the wrapped-around ones.
        if (urg_hit) begin
            win_idx = urg_idx;
        end else if (hi_hit) begin
            win_idx = hi_idx;
        end else begin
            win_idx = lo_idx;
        end
    end

`ifdef SEG_SCHED_BLINK_EN
    localparam int BW = $clog2(BLINK_MS + 1);

    logic          urg_owner;
    logic [BW-1:0] blink_cnt;
    logic          blink_show;

    // Blink phase: restarts at "shown" on every grant, advances on ticks while holding.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            urg_owner  <= 1'b0;
            blink_cnt  <= '0;
            blink_show <= 1'b1;
        end else if (state == S_ARB && any_req) begin
            urg_owner  <= urg_hit;
            blink_cnt  <= '0;
            blink_show <= 1'b1;
        end else if (state == S_HOLD && tick) begin
            if (blink_cnt == BW'(BLINK_MS - 1)) begin
                blink_cnt  <= '0;
                blink_show <= ~blink_show;
            end else begin
                blink_cnt  <= blink_cnt + 1'b1;
            end
        end
    end

    assign hold_data = (urg_owner && !blink_show) ? IDLE_BCD : owner_bcd;
`else
    assign hold_data = owner_bcd;
`endif

    // Ownership FSM with registered grant, id, display data and switch pulse.
    always_ff @(posedge clk_100mhz) begin
        if (reset) begin
            state        <= S_IDLE;
            grant        <= '0;
            active_id    <= '0;
            switch_pulse <= 1'b0;
            bcd_data_op  <= IDLE_BCD;
            dwell        <= '0;
            last_owner   <= IW'(NUM_REQ - 1);
            from_idle    <= 1'b0;
        end else begin
            switch_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    grant       <= '0;
                    bcd_data_op <= IDLE_BCD;
                    if (any_req) begin
                        state     <= S_ARB;
                        from_idle <= 1'b1;
                    end
                end
                S_ARB: begin
                    // bcd_data_op keeps its last value through this single cycle.
                    if (!any_req) begin
                        state       <= S_IDLE;
                        bcd_data_op <= IDLE_BCD;
                    end else begin
                        state        <= S_HOLD;
                        grant        <= NUM_REQ'(1) << win_idx;
                        active_id    <= win_idx;
                        last_owner   <= win_idx;
                        dwell        <= DW'(DWELL_MS);
                        // Re-granting the same owner after dwell expiry is not a switch.
                        switch_pulse <= (win_idx != active_id) || from_idle;
                        from_idle    <= 1'b0;
                    end
                end
                S_HOLD: begin
                    bcd_data_op <= hold_data;
                    if (tick && dwell != '0) begin
                        dwell <= dwell - 1'b1;
                    end
                    if (hold_exit) begin
                        state <= S_ARB;
                        grant <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_sched.sv
// Self-checking bench for seg_display_sched: directed scenarios followed by
// random req/urgent/bcd traffic, all checked every cycle against a reference model.
module tb_seg_display_sched;

    localparam int          N    = 4;
    localparam int          CD   = 10;
    localparam int          DWL  = 4;
    localparam int          BL   = 1;
    localparam logic [15:0] IDLE = 16'hFFFF;
`ifdef SEG_SCHED_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic            clk_100mhz = 1'b0;
    logic            reset      = 1'b1;
    logic [N-1:0]    req        = '0;
    logic [N-1:0]    urgent     = '0;
    logic [16*N-1:0] bcd_in     = '0;
    logic [N-1:0]    grant;
    logic [1:0]      active_id;
    logic [15:0]     bcd_data_op;
    logic            switch_pulse;

    int checks = 0;
    int errors = 0;

    seg_display_sched #(
        .NUM_REQ (N),
        .CLK_DIV (CD),
        .DWELL_MS(DWL),
        .IDLE_BCD(IDLE),
        .BLINK_MS(BL)
    ) dut (
        .clk_100mhz  (clk_100mhz),
        .reset       (reset),
        .req         (req),
        .urgent      (urgent),
        .bcd_in      (bcd_in),
        .grant       (grant),
        .active_id   (active_id),
        .bcd_data_op (bcd_data_op),
        .switch_pulse(switch_pulse)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Reference model state: mode 0=idle 1=arbitrating 2=holding.
    int          m_mode;
    int          m_ms_cnt;
    int          m_dwell;
    int          m_owner;
    int          m_last;
    int          m_ticks_held;
    bit          m_from_idle;
    bit          m_pulse;
    bit          m_urg_grant;
    logic [3:0]  m_grant;
    logic [15:0] m_bcd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Who wins a selection right now: lowest urgent requester, else next in rotation.
    function automatic int pick_winner();
        for (int i = 0; i < N; i++)
            if (req[i] && urgent[i]) return i;
        for (int d = 1; d <= N; d++)
            if (req[(m_last + d) % N]) return (m_last + d) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ms_cnt = 0; m_dwell = 0; m_owner = 0; m_last = N - 1;
        m_ticks_held = 0; m_from_idle = 0; m_pulse = 0; m_urg_grant = 0;
        m_grant = '0; m_bcd = IDLE;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit         ms_tick;
        bit         leave;
        int         w;
        logic [3:0] others_urg;
        if (reset) begin
            model_reset();
            return;
        end
        ms_tick  = (m_ms_cnt == CD - 1);
        m_ms_cnt = ms_tick ? 0 : m_ms_cnt + 1;
        m_pulse  = 0;
        case (m_mode)
            0: begin
                if (req != 0) begin
                    m_mode      = 1;
                    m_from_idle = 1;
                end
            end
            1: begin
                w = pick_winner();
                if (w < 0) begin
                    m_mode = 0;
                    m_bcd  = IDLE;
                end else begin
                    m_pulse      = (w != m_owner) || m_from_idle;
                    m_from_idle  = 0;
                    m_urg_grant  = ((req & urgent) != 0);
                    m_owner      = w;
                    m_last       = w;
                    m_grant      = 4'b0001 << w;
                    m_dwell      = DWL;
                    m_ticks_held = 0;
                    m_mode       = 2;
                end
            end
            default: begin
                if (BLINK && m_urg_grant && ((m_ticks_held / BL) % 2 == 1))
                    m_bcd = IDLE;
                else
                    m_bcd = bcd_in[16*m_owner +: 16];
                others_urg = req & urgent & ~(4'b0001 << m_owner);
                leave = !req[m_owner] || (!urgent[m_owner] && others_urg != 0) || (m_dwell == 0);
                if (ms_tick) begin
                    if (m_dwell > 0) m_dwell--;
                    m_ticks_held++;
                end
                if (leave) begin
                    m_mode  = 1;
                    m_grant = '0;
                end
            end
        endcase
    endtask

    task automatic cycle(input string tag);
        @(posedge clk_100mhz);
        model_step();
        #1;
        chk({tag, ".grant"},  32'(grant),        32'(m_grant));
        chk({tag, ".id"},     32'(active_id),    32'(m_owner));
        chk({tag, ".bcd"},    32'(bcd_data_op),  32'(m_bcd));
        chk({tag, ".pulse"},  32'(switch_pulse), 32'(m_pulse));
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    initial begin
        model_reset();
        reset = 1'b1;
        run("reset", 3);
        reset = 1'b0;

        // Single requester from IDLE.
        bcd_in[15:0]  = 16'h1234;
        bcd_in[47:32] = 16'h5678;
        req = 4'b0001;
        run("single", 20);

        // Two requesters sharing the display round-robin.
        req = 4'b0101;
        run("rr", 100);

        // Urgent preemption of owner 0, then an urgent owner that is not preempted.
        req = 4'b0001;
        run("pre0", 15);
        bcd_in[63:48] = 16'h4321;
        req = 4'b1001; urgent = 4'b1000;
        run("urg3", 10);
        req = 4'b1011; urgent = 4'b1010;
        run("urg31", 60);

        // Lone requester re-granted after each dwell expiry.
        bcd_in[31:16] = 16'h0042;
        req = 4'b0100; urgent = 4'b0000;
        run("lone", 100);

        // Drop to IDLE, then reset in the middle of HOLD.
        req = 4'b0000;
        run("drop", 10);
        req = 4'b0010;
        run("hold1", 10);
        reset = 1'b1;
        run("midrst", 1);
        reset = 1'b0;
        run("after", 5);

        // Urgent owner with fixed data (blinks only in the macro build).
        bcd_in[63:48] = 16'h0999;
        req = 4'b1000; urgent = 4'b1000;
        run("blink", 60);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) urgent = 4'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 9) == 0) bcd_in = {$urandom, $urandom};
            reset = ($urandom_range(0, 599) == 0);
            cycle("rand");
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
